// File: rtl/ref_seq_pkg.sv
// Shared types and constants for the current-reference sequencer.
// Holds the FSM state enum, the selector code map and the auto-step order.
package ref_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    WAIT_ACK
  } state_t;

  localparam logic [3:0] CODE_OFF    = 4'd0;
  localparam logic [3:0] CODE_100MA  = 4'd12;
  localparam logic [3:0] CODE_200MA  = 4'd13;
  localparam logic [3:0] CODE_400MA  = 4'd14;
  localparam logic [3:0] CODE_300MA  = 4'd15;

  // Auto mode walks the levels in ascending current order, wrapping to 100 mA.
  function automatic logic [3:0] next_auto_code(input logic [3:0] code);
    logic [3:0] nxt;
    case (code)
      CODE_100MA: nxt = CODE_200MA;
      CODE_200MA: nxt = CODE_300MA;
      CODE_300MA: nxt = CODE_400MA;
      default:    nxt = CODE_100MA;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer followed by a restartable debounce counter.
// sw_stable takes a new value once the synchronized input has held it DEB_CYCLES cycles.
module sw_debounce #(
  parameter int WIDTH      = 4,
  parameter int DEB_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_stable
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_cand;
  logic [WIDTH-1:0] r_stable;
  logic [CW-1:0]    r_cnt;

  // r_cnt counts cycles r_sync2 has matched r_cand; it saturates at CNT_MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cand   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= sw_in;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= CW'(1);
      end else if (r_cnt == CNT_MAX) begin
        r_stable <= r_cand;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign sw_stable = r_stable;

endmodule

// File: rtl/ref_sequencer.sv
// Commits debounced (or auto-stepped) reference selectors on sample boundaries with req/ack.
// Optional auto-cycle mode is compiled in when REF_SEQ_AUTO_EN is defined.
module ref_sequencer
  import ref_seq_pkg::*;
#(
  parameter int DEB_CYCLES   = 50000,
  parameter int DWELL_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_in,
  input  logic       auto_en,
  input  logic       sample_tick,
  input  logic       ref_ack,
  output logic [3:0] sel,
  output logic       ref_req,
  output logic       busy
);

  logic [3:0] w_sw_stable;
  logic [3:0] w_target;

  sw_debounce #(
    .WIDTH      (4),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_sw_debounce (
    .clk       (clk),
    .rst       (rst),
    .sw_in     (sw_in),
    .sw_stable (w_sw_stable)
  );

`ifdef REF_SEQ_AUTO_EN
  localparam int DW = $clog2(DWELL_CYCLES);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYCLES - 1);

  logic          r_auto_active;
  logic [3:0]    r_auto_code;
  logic [DW-1:0] r_dwell;

  // Leaving auto mode discards its state so the next entry restarts at 100 mA.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_auto_active <= 1'b0;
      r_auto_code   <= CODE_100MA;
      r_dwell       <= '0;
    end else if (!auto_en) begin
      r_auto_active <= 1'b0;
      r_auto_code   <= CODE_100MA;
      r_dwell       <= '0;
    end else if (!r_auto_active) begin
      r_auto_active <= 1'b1;
      r_auto_code   <= CODE_100MA;
      r_dwell       <= '0;
    end else if (r_dwell == DWELL_MAX) begin
      r_auto_code <= next_auto_code(r_auto_code);
      r_dwell     <= '0;
    end else begin
      r_dwell <= r_dwell + 1'b1;
    end
  end

  assign w_target = r_auto_active ? r_auto_code : w_sw_stable;
`else
  logic w_unused;
  assign w_unused = auto_en ^ DWELL_CYCLES[0];
  assign w_target = w_sw_stable;
`endif

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_sel;
  logic [3:0] w_sel_next;
  logic       r_req;
  logic       w_req_next;
  logic       r_busy;

  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_req_next   = r_req;
    case (r_state)
      IDLE: begin
        if (w_target != r_sel) w_state_next = PENDING;
      end
      PENDING: begin
        // A target that reverted before the tick is dropped without a request.
        if (sample_tick) begin
          if (w_target != r_sel) begin
            w_sel_next   = w_target;
            w_req_next   = 1'b1;
            w_state_next = WAIT_ACK;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      WAIT_ACK: begin
        if (ref_ack) begin
          w_req_next   = 1'b0;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= CODE_OFF;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
      r_req   <= w_req_next;
      r_busy  <= (w_state_next != IDLE);
    end
  end

  assign sel     = r_sel;
  assign ref_req = r_req;
  assign busy    = r_busy;

endmodule
